// File: rtl/basys3_input_frame_tx_if.sv
// Character stream from the frame encoder to the board UART transmitter.
// The master offers tx_data/tx_valid, and the slave accepts a character by raising tx_ready.
interface basys3_input_frame_tx_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/basys3_input_frame_tx.sv
// Samples the Basys3 switches and buttons and streams a 10-character ASCII frame
// ("S" + 4 hex + "B" + 2 hex + CR LF) to the UART when the inputs change or the refresh timer expires.
module basys3_input_frame_tx #(
  parameter int DATA_WIDTH     = 8,
  parameter int SWITCH_COUNT   = 16,
  parameter int BUTTON_COUNT   = 5,
  parameter int REFRESH_CYCLES = 5_000_000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    ena,
  input  logic [SWITCH_COUNT-1:0] switch_data,
  input  logic [BUTTON_COUNT-1:0] button_data,
  basys3_input_frame_tx_if.master tx,
  output logic                    busy,
  output logic                    frame_sent
);

  localparam int TW = (REFRESH_CYCLES > 2) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_MAX = TW'(REFRESH_CYCLES - 1);
  localparam logic [3:0]    LAST_IDX  = 4'd9;

  typedef enum logic {IDLE, SEND} state_t;

  state_t                    state, state_d;
  logic [SWITCH_COUNT-1:0]   sw_s1, sw_s2, sw_snap, sw_snap_d;
  logic [BUTTON_COUNT-1:0]   btn_s1, btn_s2, btn_snap, btn_snap_d;
  logic [SWITCH_COUNT+BUTTON_COUNT-1:0] last_sent, last_sent_d;
  logic [3:0]                idx, idx_d;
  logic [TW-1:0]             timer, timer_d;
  logic                      first_flag, first_flag_d;
  logic [DATA_WIDTH-1:0]     tx_data_q, tx_data_d;
  logic                      tx_valid_q, tx_valid_d;
  logic                      frame_sent_q, frame_sent_d;
  logic                      trigger;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    logic [7:0] c;
    c = (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    return c;
  endfunction

  function automatic logic [7:0] frame_char(input logic [3:0] i,
                                            input logic [15:0] sw,
                                            input logic [4:0]  btn);
    logic [7:0] c;
    case (i)
      4'd0:    c = 8'h53;
      4'd1:    c = hex_char(sw[15:12]);
      4'd2:    c = hex_char(sw[11:8]);
      4'd3:    c = hex_char(sw[7:4]);
      4'd4:    c = hex_char(sw[3:0]);
      4'd5:    c = 8'h42;
      4'd6:    c = hex_char({3'b000, btn[4]});
      4'd7:    c = hex_char(btn[3:0]);
      4'd8:    c = 8'h0D;
      default: c = 8'h0A;
    endcase
    return c;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sw_s1  <= '0;
      sw_s2  <= '0;
      btn_s1 <= '0;
      btn_s2 <= '0;
    end else if (ena) begin
      sw_s1  <= switch_data;
      sw_s2  <= sw_s1;
      btn_s1 <= button_data;
      btn_s2 <= btn_s1;
    end
  end

  assign trigger = first_flag || ({sw_s2, btn_s2} != last_sent) || (timer == TIMER_MAX);

  always_comb begin
    state_d      = state;
    sw_snap_d    = sw_snap;
    btn_snap_d   = btn_snap;
    last_sent_d  = last_sent;
    idx_d        = idx;
    timer_d      = timer;
    first_flag_d = first_flag;
    tx_data_d    = tx_data_q;
    tx_valid_d   = tx_valid_q;
    frame_sent_d = 1'b0;
    unique case (state)
      IDLE: begin
        if (trigger) begin
          sw_snap_d    = sw_s2;
          btn_snap_d   = btn_s2;
          idx_d        = '0;
          timer_d      = '0;
          first_flag_d = 1'b0;
          tx_valid_d   = 1'b1;
          tx_data_d    = 8'h53;
          state_d      = SEND;
        end else begin
          timer_d = timer + 1'b1;
        end
      end
      SEND: begin
        timer_d = '0;
        if (tx_valid_q && tx.tx_ready) begin
          if (idx == LAST_IDX) begin
            tx_valid_d   = 1'b0;
            frame_sent_d = 1'b1;
            last_sent_d  = {sw_snap, btn_snap};
            state_d      = IDLE;
          end else begin
            idx_d     = idx + 4'd1;
            tx_data_d = frame_char(idx + 4'd1, sw_snap, btn_snap);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // frame_sent is cleared rather than held while disabled, so a freeze cannot stretch the pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      sw_snap      <= '0;
      btn_snap     <= '0;
      last_sent    <= '0;
      idx          <= '0;
      timer        <= '0;
      first_flag   <= 1'b1;
      tx_data_q    <= '0;
      tx_valid_q   <= 1'b0;
      frame_sent_q <= 1'b0;
    end else if (ena) begin
      state        <= state_d;
      sw_snap      <= sw_snap_d;
      btn_snap     <= btn_snap_d;
      last_sent    <= last_sent_d;
      idx          <= idx_d;
      timer        <= timer_d;
      first_flag   <= first_flag_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      frame_sent_q <= frame_sent_d;
    end else begin
      frame_sent_q <= 1'b0;
    end
  end

  assign tx.tx_data  = tx_data_q;
  assign tx.tx_valid = tx_valid_q;
  assign busy        = (state == SEND);
  assign frame_sent  = frame_sent_q && ena;

endmodule

// File: tb/tb_basys3_input_frame_tx.sv
// Scoreboard bench for basys3_input_frame_tx: the stimulus pushes the expected frame bytes,
// and the monitor pops and compares them on every accepted character.
module tb_basys3_input_frame_tx;

  logic        clk;
  logic        reset_n;
  logic        ena;
  logic [15:0] switch_data;
  logic [4:0]  button_data;
  logic        tx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        busy;
  logic        frame_sent;

  basys3_input_frame_tx_if #(.DATA_WIDTH(8)) txif ();

  assign txif.tx_ready = tx_ready;
  assign tx_data       = txif.tx_data;
  assign tx_valid      = txif.tx_valid;

  basys3_input_frame_tx #(
    .DATA_WIDTH    (8),
    .SWITCH_COUNT  (16),
    .BUTTON_COUNT  (5),
    .REFRESH_CYCLES(100)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ena        (ena),
    .switch_data(switch_data),
    .button_data(button_data),
    .tx         (txif.master),
    .busy       (busy),
    .frame_sent (frame_sent)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int         n_cmp = 0;
  int         n_err = 0;
  int         accept_cnt = 0;
  logic [7:0] expq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_frame(input logic [79:0] s);
    for (int i = 9; i >= 0; i--) expq.push_back(s[i*8 +: 8]);
  endtask

  task automatic wait_frames(input int n, input bit rnd, input int budget);
    int seen;
    int cyc;
    seen = 0;
    cyc  = 0;
    while (seen < n && cyc < budget) begin
      if (rnd) tx_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      cyc++;
      if (frame_sent) seen++;
    end
    if (seen < n) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_frames: got %0d frames, required %0d within %0d cycles", seen, n, budget);
    end
    tx_ready = 1'b1;
  endtask

  task automatic wait_accepts(input int target, input int budget);
    int cyc;
    cyc = 0;
    while (accept_cnt < target && cyc < budget) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (accept_cnt < target) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_accepts: got %0d accepts, required %0d", accept_cnt, target);
    end
  endtask

  task automatic measure_gap(input string name, input int exp);
    int n;
    n = 0;
    while (!tx_valid && n < 300) begin
      n++;
      @(posedge clk); #1;
    end
    check(name, n, exp);
  endtask

  // Monitor: samples on the falling edge, so tx_valid && tx_ready here is an accept at the next rising edge
  initial begin : monitor
    bit         prev_stall;
    bit         prev_last;
    logic [7:0] prev_data;
    logic [7:0] exp_b;
    int         pos;
    prev_stall = 0;
    prev_last  = 0;
    prev_data  = '0;
    pos        = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_stall = 0;
        prev_last  = 0;
        pos        = 0;
      end else begin
        check("busy_vs_valid", {31'd0, busy}, {31'd0, tx_valid});
        if (!ena) check("frame_sent_ena_low", {31'd0, frame_sent}, 32'd0);
        else if (frame_sent || prev_last)
          check("frame_sent_pulse", {31'd0, frame_sent}, {31'd0, prev_last});
        if (prev_stall) begin
          check("stall_valid", {31'd0, tx_valid}, 32'd1);
          check("stall_data", {24'd0, tx_data}, {24'd0, prev_data});
        end
        prev_last = 0;
        if (tx_valid && tx_ready && ena) begin
          if (expq.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_byte: got %0h with nothing expected", tx_data);
          end else begin
            exp_b = expq.pop_front();
            check("byte", {24'd0, tx_data}, {24'd0, exp_b});
          end
          accept_cnt++;
          prev_last = (pos == 9);
          pos       = (pos == 9) ? 0 : pos + 1;
        end
        prev_stall = tx_valid && !(tx_ready && ena);
        prev_data  = tx_data;
      end
    end
  end

  initial begin : stimulus
    int base;
    reset_n     = 1'b0;
    ena         = 1'b1;
    switch_data = 16'h0000;
    button_data = 5'b00000;
    tx_ready    = 1'b1;

    // 1: reset values, then the first_flag frame
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_data", {24'd0, tx_data}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_frame_sent", {31'd0, frame_sent}, 32'd0);
    push_frame("S0000B00\r\n");
    reset_n = 1'b1;
    wait_frames(1, 1'b0, 200);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("idle_after_first", {31'd0, tx_valid}, 32'd0);
    end

    // 2: input change, E+2 latency
    switch_data = 16'hA5C3;
    button_data = 5'b10010;
    push_frame("SA5C3B12\r\n");
    @(posedge clk);
    @(posedge clk); #1;
    check("latency_e1_valid", {31'd0, tx_valid}, 32'd0);
    @(posedge clk); #1;
    check("latency_e2_valid", {31'd0, tx_valid}, 32'd1);
    check("latency_e2_data", {24'd0, tx_data}, 32'h53);
    wait_frames(1, 1'b0, 200);

    // 3: random tx_ready stalls
    switch_data = 16'h1234;
    button_data = 5'b01111;
    push_frame("S1234B0F\r\n");
    wait_frames(1, 1'b1, 2000);

    // 4: change mid-frame leaves the frame in flight intact
    base = accept_cnt;
    switch_data = 16'h0001;
    button_data = 5'b00000;
    push_frame("S0001B00\r\n");
    push_frame("S0002B00\r\n");
    wait_accepts(base + 3, 200);
    switch_data = 16'h0002;
    wait_frames(2, 1'b0, 400);

    // 5: refresh frames 100 idle cycles apart
    push_frame("S0002B00\r\n");
    push_frame("S0002B00\r\n");
    measure_gap("refresh_gap_1", 100);
    wait_frames(1, 1'b0, 200);
    measure_gap("refresh_gap_2", 100);
    wait_frames(1, 1'b0, 200);

    // 6: reset at idx 6, ena frozen, restart from 'S'
    base = accept_cnt;
    switch_data = 16'hBEEF;
    button_data = 5'b00001;
    push_frame("SBEEFB01\r\n");
    wait_accepts(base + 6, 200);
    #1;
    reset_n = 1'b0;
    #1;
    check("abort_valid", {31'd0, tx_valid}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_data", {24'd0, tx_data}, 32'd0);
    expq.delete();
    ena      = 1'b0;
    tx_ready = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("frozen_idle_valid", {31'd0, tx_valid}, 32'd0);
    end
    // synchronisers were cleared and frozen, so the first_flag frame carries zeros
    base = accept_cnt;
    push_frame("S0000B00\r\n");
    push_frame("SBEEFB01\r\n");
    ena      = 1'b1;
    tx_ready = 1'b1;
    wait_accepts(base + 12, 400);
    ena      = 1'b0;
    tx_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("frozen_send_valid", {31'd0, tx_valid}, 32'd1);
      check("frozen_send_data", {24'd0, tx_data}, 32'h45);
    end
    ena      = 1'b1;
    tx_ready = 1'b1;
    wait_frames(1, 1'b0, 200);

    repeat (5) @(posedge clk);
    #1;
    check("queue_empty", expq.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
